wb_retire_unit: RTL

- Write-back stage of the 5-stage MIPS pipeline. It is the producer side of the register file's single write port.
- Accepts in-order results from the MEM stage into a small queue and holds loads until the data memory returns read data.
- Performs load byte/half extraction and sign/zero extension, then drives the register-file write port (we/addr/data).
- Exports forwarding and pending-load information to the hazard/forwarding logic.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/wb_retire_unit_if.sv | 30 +++
 rtl/wb_retire_unit_load_extend.sv | 44 ++++
 rtl/wb_retire_unit.sv | 90 +++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: load-type encodings, default widths and
// the retire-queue entry layout used by the write-back stage.
package mips_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  localparam logic [2:0] LOAD_LW  = 3'd0;
  localparam logic [2:0] LOAD_LB  = 3'd1;
  localparam logic [2:0] LOAD_LBU = 3'd2;
  localparam logic [2:0] LOAD_LH  = 3'd3;
  localparam logic [2:0] LOAD_LHU = 3'd4;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [2:0]        load_type;
    logic [1:0]        addr_lo;
    logic [AW_DEF-1:0] write_reg;
    logic [DW_DEF-1:0] alu_result;
  } retire_entry_t;

endpackage

// File: rtl/wb_retire_unit_if.sv
// MEM-stage result channel plus data-memory read response into write-back.
interface wb_retire_unit_if
  import mips_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);
  logic          in_valid;
  logic          in_ready;
  logic          in_reg_write;
  logic          in_mem_to_reg;
  logic [2:0]    in_load_type;
  logic [1:0]    in_addr_lo;
  logic [AW-1:0] in_write_reg;
  logic [DW-1:0] in_alu_result;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport master (
    output in_valid, in_reg_write, in_mem_to_reg, in_load_type, in_addr_lo,
    output in_write_reg, in_alu_result, mem_rvalid, mem_rdata,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_reg_write, in_mem_to_reg, in_load_type, in_addr_lo,
    input  in_write_reg, in_alu_result, mem_rvalid, mem_rdata,
    output in_ready
  );
endinterface

// File: rtl/wb_retire_unit_load_extend.sv
// Load lane extraction and sign/zero extension; flags misaligned LW/LH/LHU.
module load_extend
  import mips_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [2:0]    load_type,
  input  logic [1:0]    addr_lo,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] data,
  output logic          misaligned
);
  logic        [7:0]    byte_u;
  logic        [15:0]   half_u;
  logic signed [7:0]    byte_s;
  logic signed [15:0]   half_s;
  logic signed [DW-1:0] byte_x;
  logic signed [DW-1:0] half_x;

  always_comb begin
    byte_u = rdata[{addr_lo, 3'b000} +: 8];
    half_u = rdata[{addr_lo[1], 4'b0000} +: 16];
    byte_s = $signed(byte_u);
    half_s = $signed(half_u);
    byte_x = byte_s;
    half_x = half_s;
    data       = rdata;
    misaligned = 1'b0;
    case (load_type)
      LOAD_LB:  data = byte_x;
      LOAD_LBU: data = {{(DW-8){1'b0}}, byte_u};
      LOAD_LH: begin
        data       = half_x;
        misaligned = addr_lo[0];
      end
      LOAD_LHU: begin
        data       = {{(DW-16){1'b0}}, half_u};
        misaligned = addr_lo[0];
      end
      // LW and the reserved encodings take the whole word
      default:  misaligned = (addr_lo != 2'b00);
    endcase
  end
endmodule

// File: rtl/wb_retire_unit.sv
// Write-back stage: in-order retire queue feeding the register-file write
// port, holding loads at the head until their memory response arrives.
module wb_retire_unit
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_retire_unit_if.slave bus,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [DW-1:0]   rf_wdata,
  output logic            load_pending,
  output logic [AW-1:0]   load_pending_reg,
  output logic            err_resp,
  output logic            err_misalign
);
  localparam int PW = $clog2(DEPTH);

  retire_entry_t q [DEPTH];
  retire_entry_t entry_in;
  retire_entry_t head;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          has_head, enq, retire, resp_err, mis, ld_mis;
  logic [DW-1:0] ld_data, wdata_sel;

  always_comb begin
    entry_in.reg_write  = bus.in_reg_write;
    entry_in.mem_to_reg = bus.in_mem_to_reg;
    entry_in.load_type  = bus.in_load_type;
    entry_in.addr_lo    = bus.in_addr_lo;
    entry_in.write_reg  = bus.in_write_reg;
    entry_in.alu_result = bus.in_alu_result;
  end

  // Readiness looks only at occupancy, so a full queue stalls even on a retire
  assign bus.in_ready = (count < (PW+1)'(DEPTH));
  assign enq          = bus.in_valid && bus.in_ready;
  assign head         = q[rd_ptr];
  assign has_head     = (count != '0);
  assign load_pending = has_head && head.mem_to_reg;
  assign load_pending_reg = load_pending ? head.write_reg : '0;
  assign retire       = has_head && (!head.mem_to_reg || bus.mem_rvalid);
  assign resp_err     = bus.mem_rvalid && !load_pending;

  load_extend #(.DW(DW)) u_load_extend (
    .load_type  (head.load_type),
    .addr_lo    (head.addr_lo),
    .rdata      (bus.mem_rdata),
    .data       (ld_data),
    .misaligned (ld_mis)
  );

  assign mis       = head.mem_to_reg && ld_mis;
  assign wdata_sel = head.mem_to_reg ? ld_data : head.alu_result;

  // Queue storage: pointers alone define validity, so entries need no reset
  always_ff @(posedge clk) begin
    if (enq) q[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      err_resp     <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      if (enq)    wr_ptr <= wr_ptr + PW'(1);
      if (retire) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(enq) - (PW+1)'(retire);
      // $0 writes are dropped here because the register file does not guard r0
      rf_we <= retire && head.reg_write && (head.write_reg != '0) && !mis;
      if (retire) begin
        rf_waddr <= head.write_reg;
        rf_wdata <= wdata_sel;
      end
      if (resp_err)      err_resp     <= 1'b1;
      if (retire && mis) err_misalign <= 1'b1;
    end
  end
endmodule
